// File: rtl/hbc_mcp_host.sv
// hbc_mcp_host
//
// Host-side sequencer for a byte-wide multiply coprocessor. A start request
// latches two 16-bit operands and writes them as four bytes to coprocessor
// addresses 0..3. It then waits out the multiply settle time and reads the
// 32-bit product back as four bytes from addresses 0..3. The raw bytes are
// presented on result with a one-cycle done pulse. This block performs no
// arithmetic of its own.
//
// Bus timing is set by the parameters below, in clk cycles:
//   SETUP_CYC  : address/data valid before a strobe falls (>= 1)
//   STROBE_CYC : strobe low time (>= 1)
//   HOLD_CYC   : address/data held after a strobe rises (>= 1)
//   SETTLE_CYC : idle gap between the last write and the first read (>= 0)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request one multiply (sampled only when idle)
//   a_in     in   16-bit operand A
//   b_in     in   16-bit operand B
//   busy     out  high from the cycle after acceptance through the done cycle
//   done     out  one-cycle pulse, result valid
//   result   out  32-bit product bytes as read back
//   WRn      out  active-low write strobe
//   RDn      out  active-low read strobe
//   address  out  coprocessor byte address (bit 2 always 0)
//   data_o   out  write data
//   data_oe  out  shared-bus output enable, high only while writing
//   data_i   in   read data from the shared bus

module hbc_mcp_host #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        WRn,
    output logic        RDn,
    output logic [2:0]  address,
    output logic [7:0]  data_o,
    output logic        data_oe,
    input  logic [7:0]  data_i
);

    typedef enum logic [3:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        SETTLE,
        R_SETUP,
        R_STROBE,
        R_HOLD,
        DONE
    } state_t;

    // Terminal values of the phase counter for each bus phase. The settle
    // terminal value wraps when SETTLE_CYC is 0, but the settle state is
    // never entered in that case.
    localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYC - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYC - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] phase;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [31:0] shadow;

    // Write byte order: A high, A low, B high, B low.
    function automatic logic [7:0] byte_sel(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [1:0]  i);
        case (i)
            2'd0:    return a[15:8];
            2'd1:    return a[7:0];
            2'd2:    return b[15:8];
            default: return b[7:0];
        endcase
    endfunction

    // The whole sequencer lives in this block. Every bus output is a
    // register, so strobes, address and data change only on clock edges and
    // never glitch. Each bus state counts its own length with the phase
    // counter and clears it on exit. Address and data are loaded on the edge
    // entering a setup phase and stay put until the next access begins.
    // Read bytes collect in a shadow register, so result only ever shows a
    // complete product, copied on the edge that enters DONE. Reset
    // immediately returns every strobe high and drops busy, so an aborted
    // transfer issues no further strobe and produces no done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            phase   <= 16'd0;
            a_reg   <= 16'd0;
            b_reg   <= 16'd0;
            shadow  <= 32'd0;
            WRn     <= 1'b1;
            RDn     <= 1'b1;
            data_oe <= 1'b0;
            address <= 3'd0;
            data_o  <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        idx     <= 2'd0;
                        phase   <= 16'd0;
                        address <= 3'd0;
                        data_o  <= a_in[15:8];
                        data_oe <= 1'b1;
                        busy    <= 1'b1;
                        state   <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (phase == SETUP_LAST) begin
                        phase <= 16'd0;
                        WRn   <= 1'b0;
                        state <= W_STROBE;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                W_STROBE: begin
                    if (phase == STROBE_LAST) begin
                        phase <= 16'd0;
                        WRn   <= 1'b1;
                        state <= W_HOLD;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                W_HOLD: begin
                    if (phase == HOLD_LAST) begin
                        phase <= 16'd0;
                        if (idx == 2'd3) begin
                            data_oe <= 1'b0;
                            if (SETTLE_CYC == 0) begin
                                idx     <= 2'd0;
                                address <= 3'd0;
                                state   <= R_SETUP;
                            end else begin
                                state <= SETTLE;
                            end
                        end else begin
                            idx     <= idx + 2'd1;
                            address <= {1'b0, idx + 2'd1};
                            data_o  <= byte_sel(a_reg, b_reg, idx + 2'd1);
                            state   <= W_SETUP;
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                SETTLE: begin
                    if (phase == SETTLE_LAST) begin
                        phase   <= 16'd0;
                        idx     <= 2'd0;
                        address <= 3'd0;
                        state   <= R_SETUP;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                R_SETUP: begin
                    if (phase == SETUP_LAST) begin
                        phase <= 16'd0;
                        RDn   <= 1'b0;
                        state <= R_STROBE;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                R_STROBE: begin
                    if (phase == STROBE_LAST) begin
                        phase <= 16'd0;
                        RDn   <= 1'b1;
                        case (idx)
                            2'd0:    shadow[31:24] <= data_i;
                            2'd1:    shadow[23:16] <= data_i;
                            2'd2:    shadow[15:8]  <= data_i;
                            default: shadow[7:0]   <= data_i;
                        endcase
                        state <= R_HOLD;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                R_HOLD: begin
                    if (phase == HOLD_LAST) begin
                        phase <= 16'd0;
                        if (idx == 2'd3) begin
                            done   <= 1'b1;
                            result <= shadow;
                            state  <= DONE;
                        end else begin
                            idx     <= idx + 2'd1;
                            address <= {1'b0, idx + 2'd1};
                            state   <= R_SETUP;
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hbc_mcp_host.sv
// tb_hbc_mcp_host
//
// Bench for hbc_mcp_host. Two hosts are instantiated: one with default bus
// timing and one with minimal timing (1/1/1 and no settle). Each host talks
// to its own behavioural signed 16x16 multiply coprocessor. Scenario tasks
// run in sequence from a single initial block. A bus monitor watches both
// hosts for strobe overlap and for bus drive during a read.

module tb_hbc_mcp_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] a_in = 16'd0;
    logic [15:0] b_in = 16'd0;

    logic        busy, done, WRn, RDn, data_oe;
    logic [31:0] result;
    logic [2:0]  address;
    logic [7:0]  data_o, data_i;

    logic        busy2, done2, wrn2, rdn2, oe2;
    logic [31:0] result2;
    logic [2:0]  address2;
    logic [7:0]  data_o2, data_i2;

    int checks_total  = 0;
    int checks_passed = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    hbc_mcp_host u_dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .WRn(WRn), .RDn(RDn),
        .address(address), .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
    );

    hbc_mcp_host #(
        .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .SETTLE_CYC(0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a_in), .b_in(b_in),
        .busy(busy2), .done(done2), .result(result2), .WRn(wrn2), .RDn(rdn2),
        .address(address2), .data_o(data_o2), .data_oe(oe2), .data_i(data_i2)
    );

    // Coprocessor models: they capture a byte on every strobed write clock
    // and return the signed product byte for the addressed slot while the
    // read strobe is low. With no read strobe they return a marker value.
    logic [7:0]  cp_reg  [4];
    logic [7:0]  cp2_reg [4];
    logic [15:0] cp_a, cp_b, cp2_a, cp2_b;
    logic [31:0] cp_prod, cp2_prod;

    always @(posedge clk) begin
        if (!WRn && data_oe) cp_reg[address[1:0]] <= data_o;
        if (!wrn2 && oe2) cp2_reg[address2[1:0]] <= data_o2;
    end

    assign cp_a     = {cp_reg[0], cp_reg[1]};
    assign cp_b     = {cp_reg[2], cp_reg[3]};
    assign cp2_a    = {cp2_reg[0], cp2_reg[1]};
    assign cp2_b    = {cp2_reg[2], cp2_reg[3]};
    assign cp_prod  = 32'($signed(cp_a)) * 32'($signed(cp_b));
    assign cp2_prod = 32'($signed(cp2_a)) * 32'($signed(cp2_b));

    always_comb begin
        data_i = 8'hEE;
        if (!RDn) begin
            case (address[1:0])
                2'd0:    data_i = cp_prod[31:24];
                2'd1:    data_i = cp_prod[23:16];
                2'd2:    data_i = cp_prod[15:8];
                default: data_i = cp_prod[7:0];
            endcase
        end
    end

    always_comb begin
        data_i2 = 8'hEE;
        if (!rdn2) begin
            case (address2[1:0])
                2'd0:    data_i2 = cp2_prod[31:24];
                2'd1:    data_i2 = cp2_prod[23:16];
                2'd2:    data_i2 = cp2_prod[15:8];
                default: data_i2 = cp2_prod[7:0];
            endcase
        end
    end

    // Bus monitor: strobes never overlap, and the bus is never driven while
    // a read strobe is low, on either host.
    always @(negedge clk) begin
        if (mon_en) begin
            checks_total++;
            if ((!WRn && !RDn) || (data_oe && !RDn) || (!wrn2 && !rdn2) || (oe2 && !rdn2))
                $display("[TB] FAIL bus_monitor t=%0t got WRn=%b RDn=%b oe=%b WRn2=%b RDn2=%b oe2=%b, need no overlap/no drive in read",
                         $time, WRn, RDn, data_oe, wrn2, rdn2, oe2);
            else
                checks_passed++;
        end
    end

    // Reset holds every output at its idle value, and a start that arrives
    // together with reset is not accepted.
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a_in = 16'h1111;
        b_in = 16'h2222;
        @(negedge clk);
        @(negedge clk);
        checks_total++;
        if ({WRn, RDn, data_oe, address, data_o, busy, done, result} !== {1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 32'd0})
            $display("[TB] FAIL reset_state got WRn=%b RDn=%b oe=%b addr=%0d data=%h busy=%b done=%b result=%h",
                     WRn, RDn, data_oe, address, data_o, busy, done, result);
        else
            checks_passed++;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks_total++;
        if ({busy, WRn, data_oe} !== 3'b010)
            $display("[TB] FAIL start_with_reset got busy=%b WRn=%b oe=%b, need busy=0 WRn=1 oe=0", busy, WRn, data_oe);
        else
            checks_passed++;
    endtask

    // One full default-timing transaction, checked cycle by cycle: write
    // bytes 12,34,56,78 with a setup/strobe/strobe/hold pattern, two settle
    // cycles, four reads, done in cycle 35, busy cleared in cycle 36.
    task automatic test_write_sequence();
        logic [7:0]  wbytes [4];
        logic [7:0]  exp_data, obs_data;
        logic [2:0]  exp_addr, obs_addr;
        logic        exp_wr, exp_rd, exp_oe, exp_busy, exp_done;
        logic [31:0] exp_res;
        int          k, m;
        wbytes[0] = 8'h12;
        wbytes[1] = 8'h34;
        wbytes[2] = 8'h56;
        wbytes[3] = 8'h78;
        a_in  = 16'h1234;
        b_in  = 16'h5678;
        start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            exp_wr   = 1'b1;
            exp_rd   = 1'b1;
            exp_oe   = 1'b0;
            exp_addr = 3'd0;
            exp_data = 8'd0;
            obs_addr = 3'd0;
            obs_data = 8'd0;
            exp_busy = (c <= 35);
            exp_done = (c == 35);
            exp_res  = (c >= 35) ? 32'h0626_0060 : 32'h0;
            if (c <= 16) begin
                k = (c - 1) / 4;
                m = (c - 1) % 4;
                exp_wr   = (m == 1 || m == 2) ? 1'b0 : 1'b1;
                exp_oe   = 1'b1;
                exp_addr = 3'(k);
                exp_data = wbytes[k];
                obs_addr = address;
                obs_data = data_o;
            end else if (c >= 19 && c <= 34) begin
                k = (c - 19) / 4;
                m = (c - 19) % 4;
                exp_rd   = (m == 1 || m == 2) ? 1'b0 : 1'b1;
                exp_addr = 3'(k);
                obs_addr = address;
            end
            checks_total++;
            if ({busy, done, WRn, RDn, data_oe, obs_addr, obs_data, result} !==
                {exp_busy, exp_done, exp_wr, exp_rd, exp_oe, exp_addr, exp_data, exp_res})
                $display("[TB] FAIL wr_seq cycle %0d got busy=%b done=%b WRn=%b RDn=%b oe=%b addr=%0d data=%h result=%h, need %b %b %b %b %b %0d %h %h",
                         c, busy, done, WRn, RDn, data_oe, obs_addr, obs_data, result,
                         exp_busy, exp_done, exp_wr, exp_rd, exp_oe, exp_addr, exp_data, exp_res);
            else
                checks_passed++;
        end
    endtask

    // One multiply on the default host: done in cycle 35 with the expected
    // product, and done lasting exactly one cycle.
    task automatic test_multiply(input logic [15:0] a, input logic [15:0] b,
                                 input logic [31:0] exp_res);
        int got = 0;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                got = c;
                break;
            end
        end
        checks_total++;
        if (got != 35)
            $display("[TB] FAIL mult_done_cycle a=%h b=%h got cycle %0d, need 35", a, b, got);
        else
            checks_passed++;
        checks_total++;
        if (result !== exp_res)
            $display("[TB] FAIL mult_result a=%h b=%h got %h, need %h", a, b, result, exp_res);
        else
            checks_passed++;
        @(negedge clk);
        checks_total++;
        if ({done, busy} !== 2'b00)
            $display("[TB] FAIL mult_done_width got done=%b busy=%b after done, need 0 0", done, busy);
        else
            checks_passed++;
    endtask

    // Minimal-timing host: done in cycle 25 with a negative product.
    task automatic test_min_timing();
        int got = 0;
        a_in   = 16'h8000;
        b_in   = 16'h0002;
        start2 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            if (done2) begin
                got = c;
                break;
            end
        end
        checks_total++;
        if (got != 25)
            $display("[TB] FAIL min_done_cycle got cycle %0d, need 25", got);
        else
            checks_passed++;
        checks_total++;
        if (result2 !== 32'hFFFF_0000)
            $display("[TB] FAIL min_result got %h, need ffff0000", result2);
        else
            checks_passed++;
        @(negedge clk);
        checks_total++;
        if ({done2, busy2} !== 2'b00)
            $display("[TB] FAIL min_done_width got done=%b busy=%b, need 0 0", done2, busy2);
        else
            checks_passed++;
    endtask

    // Start pulses mid-transfer and during DONE are ignored: one done only.
    task automatic test_start_ignored();
        int ndone = 0;
        int first = 0;
        a_in  = 16'h0100;
        b_in  = 16'h0100;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1 || c == 6 || c == 36) start = 1'b0;
            if (c == 5 || c == 35) start = 1'b1;
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        checks_total++;
        if (ndone != 1 || first != 35)
            $display("[TB] FAIL ignore_start got %0d dones first at %0d, need 1 at 35", ndone, first);
        else
            checks_passed++;
        checks_total++;
        if ({busy, result} !== {1'b0, 32'h0001_0000})
            $display("[TB] FAIL ignore_start_end got busy=%b result=%h, need 0 00010000", busy, result);
        else
            checks_passed++;
    endtask

    // Reset during the second read strobe aborts cleanly, then a fresh
    // multiply completes normally.
    task automatic test_reset_mid_read();
        int ndone = 0;
        int got = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks_total++;
        if (result !== 32'd0)
            $display("[TB] FAIL reset_clears_result got %h, need 00000000", result);
        else
            checks_passed++;
        a_in  = 16'h1234;
        b_in  = 16'h5678;
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        checks_total++;
        if ({RDn, address} !== {1'b0, 3'd1})
            $display("[TB] FAIL in_second_read got RDn=%b addr=%0d, need 0 1", RDn, address);
        else
            checks_passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks_total++;
        if ({RDn, WRn, busy, done, data_oe, result} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0})
            $display("[TB] FAIL abort_state got RDn=%b WRn=%b busy=%b done=%b oe=%b result=%h, need 1 1 0 0 0 0",
                     RDn, WRn, busy, done, data_oe, result);
        else
            checks_passed++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done || busy || !RDn || !WRn) ndone++;
        end
        checks_total++;
        if (ndone != 0)
            $display("[TB] FAIL abort_quiet got %0d active cycles after abort, need 0", ndone);
        else
            checks_passed++;
        a_in  = 16'h0007;
        b_in  = 16'h0006;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                got = c;
                break;
            end
        end
        checks_total++;
        if (got != 35 || result !== 32'h0000_002A)
            $display("[TB] FAIL after_abort got cycle %0d result %h, need 35 0000002a", got, result);
        else
            checks_passed++;
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_write_sequence();
        @(negedge clk);
        test_multiply(16'h0003, 16'h0004, 32'h0000_000C);
        test_multiply(16'hFFFF, 16'h0002, 32'hFFFF_FFFE);
        test_min_timing();
        test_start_ignored();
        test_reset_mid_read();
        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/hbc_mcp_host.md
HBC_MCP_HOST -- requirements
Module: hbc_mcp_host

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles address/data are driven before each strobe falls (min 1).
REQ-002 SHALL have parameter STROBE_CYC, default 2: cycles WRn/RDn are held low per access (min 1).
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles address/data are held after each strobe rises (min 1).
REQ-004 SHALL have parameter SETTLE_CYC, default 2: idle cycles between the last write and the first read, covering coprocessor multiply settle (min 0).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-006 clk  in  1  system clock; all state changes on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request one multiply; sampled only in IDLE.
REQ-009 a_in  in  16  operand A, captured on start acceptance.
REQ-010 b_in  in  16  operand B, captured on start acceptance.
REQ-011 busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-012 done  out  1  one-cycle pulse; result valid.
REQ-013 result  out  32  product bytes as read back; holds until the next done.
REQ-014 WRn  out  1  active-low write strobe to coprocessor.
REQ-015 RDn  out  1  active-low read strobe to coprocessor.
REQ-016 address  out  3  coprocessor byte address; bit 2 always 0.
REQ-017 data_o  out  8  write data; top level drives the shared bus when data_oe=1.
REQ-018 data_oe  out  1  bus output enable; high only during write phases.
REQ-019 data_i  in  8  read data from shared bus.

Function
REQ-020 States SHALL be IDLE, W_SETUP, W_STROBE, W_HOLD, SETTLE, R_SETUP, R_STROBE, R_HOLD, DONE, with a 2-bit byte index and a phase counter.
REQ-021 IDLE with start=1 SHALL latch a_in/b_in, clear the byte index, and enter W_SETUP; start=0 or start in any other state is ignored.
REQ-022 Writes SHALL be issued in order: addr 0 = A[15:8], 1 = A[7:0], 2 = B[15:8], 3 = B[7:0].
REQ-023 Each write SHALL be W_SETUP (SETUP_CYC, WRn=1, data_oe=1), then W_STROBE (STROBE_CYC, WRn=0), then W_HOLD (HOLD_CYC, WRn=1, data_oe=1); address/data_o are stable across all three phases.
REQ-024 After the write with index 3 completes, the block SHALL enter SETTLE for SETTLE_CYC cycles (skipped if 0), with data_oe=0 and both strobes high.
REQ-025 Reads SHALL be issued to addr 0,1,2,3, filling result bytes [31:24],[23:16],[15:8],[7:0] of a shadow register.
REQ-026 Each read SHALL be R_SETUP (SETUP_CYC, RDn=1), R_STROBE (STROBE_CYC, RDn=0), R_HOLD (HOLD_CYC, RDn=1); data_i is sampled on the clock edge ending the final R_STROBE cycle.
REQ-027 data_oe SHALL be 0 in every read, SETTLE, IDLE and DONE cycle; WRn and RDn SHALL never be low in the same cycle.
REQ-028 After the read with index 3, the block SHALL enter DONE for one cycle: done=1, busy=1, result updated from the shadow at the entering edge; next state IDLE.
REQ-029 Busy length SHALL be N+1 cycles, where N = 8*(SETUP_CYC+STROBE_CYC+HOLD_CYC)+SETTLE_CYC (defaults: N=34, done in 35th cycle after acceptance).
REQ-030 result SHALL change only on DONE entry; partial reads never appear on result.
REQ-031 The block SHALL perform no arithmetic; result is the raw bytes read back.

Reset
REQ-032 With rst=1 on an edge, the block SHALL enter IDLE and set WRn=1, RDn=1, data_oe=0, address=0, data_o=0, busy=0, done=0, result=0.
REQ-033 Reset mid-transfer SHALL abort on that edge with no further strobe; an in-flight strobe is released high and no done is produced.
REQ-034 start asserted together with rst SHALL be ignored.

Verification
REQ-035 A=0x1234, B=0x5678 -> write bus sequence (addr,data) = (0,0x12),(1,0x34),(2,0x56),(3,0x78), each WRn low exactly 2 cycles, data stable 1 cycle before and after.
REQ-036 Against a behavioural signed 16x16 coprocessor model: A=0x0003, B=0x0004 -> result=0x0000000C; A=0xFFFF, B=0x0002 -> result=0xFFFFFFFE, done exactly one cycle.
REQ-037 Defaults -> done in the 35th cycle after the start edge; with SETTLE_CYC=0, SETUP=HOLD=STROBE=1 -> done in the 25th cycle.
REQ-038 start pulsed again at cycles 5 and 35 (DONE) of a run -> ignored; exactly one transaction, one done.
REQ-039 rst asserted during 2nd read strobe -> next cycle RDn=1, busy=0, result unchanged (0), no done; new start then completes normally.
REQ-040 Bus monitor over all tests -> WRn and RDn never simultaneously low; data_oe never high while RDn=0.
